// File: rtl/lms_pkg.sv
// Shared constants, saturation helper and FSM state encoding for the LMS
// adaptive-filter datapath; reused by the core FSM and the output stage.
package lms_pkg;

  localparam int unsigned FRAC = 15;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } lms_state_e;

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -64'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/lms_tap_alu.sv
// One filter tap: weighted product for the accumulator and the LMS-updated,
// saturated weight. Purely combinational.
module lms_tap_alu #(
  parameter int unsigned FRAC  = 15,
  parameter int unsigned ACC_W = 40
) (
  input  logic signed [15:0]      w,
  input  logic signed [15:0]      x,
  input  logic signed [15:0]      mu_e,
  output logic signed [ACC_W-1:0] prod,
  output logic signed [15:0]      w_next
);
  import lms_pkg::*;

  logic signed [31:0] wx;
  logic signed [31:0] mx;
  logic signed [33:0] w_sum;

  always_comb begin
    wx     = 32'(w) * 32'(x);
    mx     = 32'(mu_e) * 32'(x);
    prod   = ACC_W'(wx);
    // arithmetic shift floors toward -inf; no rounding term is added
    w_sum  = 34'(w) + 34'(mx >>> FRAC);
    w_next = sat16(64'(w_sum));
  end

endmodule

// File: rtl/lms_fir_engine.sv
// Adaptive FIR responder: on fir_go shifts in a sample, runs one tap per cycle
// with in-place LMS weight update, then pulses fir_done with the new y_out.
module lms_fir_engine #(
  parameter int unsigned TAPS  = 16,
  parameter int unsigned FRAC  = lms_pkg::FRAC,
  parameter int unsigned ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fir_go,
  input  logic signed [31:0] feedforward_in,
  input  logic signed [31:0] weight_adjust,
  output logic signed [15:0] y_out,
  output logic               fir_done,
  output logic               busy
);
  import lms_pkg::*;

  localparam int unsigned K_W = $clog2(TAPS);

  lms_state_e state, state_next;

  logic signed [15:0]      w_q [TAPS];
  logic signed [15:0]      x_q [TAPS];
  logic signed [15:0]      mu_e;
  logic signed [ACC_W-1:0] acc;
  logic [K_W-1:0]          k;

  logic                    accept;
  logic                    mac_step;
  logic                    finish;
  logic                    last_tap;
  logic signed [ACC_W-1:0] tap_prod;
  logic signed [15:0]      tap_w_next;

  assign last_tap = (k == K_W'(TAPS - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mac_step   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (fir_go) begin
          accept     = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (last_tap) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  lms_tap_alu #(
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_tap_alu (
    .w      (w_q[k]),
    .x      (x_q[k]),
    .mu_e   (mu_e),
    .prod   (tap_prod),
    .w_next (tap_w_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      mu_e     <= '0;
      acc      <= '0;
      k        <= '0;
      y_out    <= '0;
      fir_done <= 1'b0;
    end else begin
      fir_done <= 1'b0;
      if (accept) begin
        for (int unsigned i = TAPS - 1; i > 0; i--) begin
          x_q[i] <= x_q[i-1];
        end
        x_q[0] <= sat16(64'(feedforward_in));
        mu_e   <= sat16(64'(weight_adjust >>> FRAC));
        acc    <= '0;
        k      <= '0;
      end
      // accumulate with the pre-update weight, then overwrite it in place
      if (mac_step) begin
        acc    <= acc + tap_prod;
        w_q[k] <= tap_w_next;
        if (!last_tap) begin
          k <= k + 1'b1;
        end
      end
      if (finish) begin
        y_out    <= sat16(64'(acc >>> FRAC));
        fir_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lms_fir_engine.sv
// Scoreboard bench for lms_fir_engine: directed operations push expected
// results; a negedge monitor pops and checks them whenever fir_done is seen.
module tb_lms_fir_engine;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               fir_go = 1'b0;
  logic signed [31:0] feedforward_in = '0;
  logic signed [31:0] weight_adjust = '0;
  logic signed [15:0] y_out;
  logic               fir_done;
  logic               busy;

  typedef struct {
    logic signed [15:0] y;
    int                 cyc;
    string              name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  lms_fir_engine #(
    .TAPS  (16),
    .FRAC  (15),
    .ACC_W (40)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fir_go         (fir_go),
    .feedforward_in (feedforward_in),
    .weight_adjust  (weight_adjust),
    .y_out          (y_out),
    .fir_done       (fir_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (fir_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fir_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_y"}, int'(y_out), int'(mon_e.y));
        check({mon_e.name, "_latency"}, cyc, mon_e.cyc);
      end
    end
  end

  // Called at a negedge; leaves the bench at a negedge with rst low.
  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // glitch_at / abort_at: edge index (after the accepting edge E0) at which a
  // stray fir_go is sampled / before which rst is asserted; 0 disables.
  task automatic run_op(input string name, input logic signed [31:0] ff,
                        input logic signed [31:0] wa, input int exp_y,
                        input bit expect_done, input int glitch_at,
                        input int abort_at);
    int  nb;
    bit  done;
    fir_go         = 1'b1;
    feedforward_in = ff;
    weight_adjust  = wa;
    if (expect_done) exp_q.push_back('{y: 16'(exp_y), cyc: cyc + 18, name: name});
    @(negedge clk);
    fir_go         = 1'b0;
    feedforward_in = 32'sh0BAD_F00D;
    weight_adjust  = 32'sh7FFF_FFFF;
    nb   = 0;
    done = 1'b0;
    for (int t = 1; t <= 40 && !done; t++) begin
      fir_go = 1'b0;
      if (fir_done) begin
        done = 1'b1;
      end else begin
        if (busy) nb++;
        if (t == glitch_at) begin
          fir_go         = 1'b1;
          feedforward_in = -32'sd16384;
          weight_adjust  = 32'sh4000_0000;
        end
        if (t == abort_at) begin
          #2 rst = 1'b1;
          #1;
          check({name, "_rst_y_out"}, int'(y_out), 0);
          check({name, "_rst_busy"}, int'(busy), 0);
          check({name, "_rst_fir_done"}, int'(fir_done), 0);
          #1 rst = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    if (!done) check({name, "_timeout"}, 1, 0);
    else       check({name, "_busy_cycles"}, nb, 17);
  endtask

  initial begin
    #3 rst = 1'b1;
    #1;
    check("reset_y_out", int'(y_out), 0);
    check("reset_fir_done", int'(fir_done), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("latency", 32'sd16384, 32'sd0, 0, 1'b1, 0, 0);

    do_reset();
    run_op("learn1", 32'sd16384, 32'sh2000_0000, 0,     1'b1, 5,  0);
    run_op("learn2", 32'sd16384, 32'sh2000_0000, 4096,  1'b1, 17, 0);
    run_op("learn3", 32'sd16384, 32'sh2000_0000, 12288, 1'b1, 0,  0);
    run_op("learn4", 32'sd16384, 32'sh2000_0000, 24576, 1'b1, 0,  0);

    do_reset();
    run_op("sat1", 32'sh0001_0000, 32'sh3FFF_8000, 0,     1'b1, 0, 0);
    run_op("sat2", 32'sh0001_0000, 32'sh3FFF_8000, 32765, 1'b1, 0, 0);
    for (int i = 3; i <= 11; i++) begin
      run_op($sformatf("sat%0d", i), 32'sh0001_0000, 32'sh3FFF_8000, 32767, 1'b1, 0, 0);
    end

    do_reset();
    run_op("abort1", 32'sd16384, 32'sh2000_0000, 0,    1'b1, 0, 0);
    run_op("abort2", 32'sd16384, 32'sh2000_0000, 4096, 1'b1, 0, 0);
    run_op("abort3", 32'sd16384, 32'sh2000_0000, 0,    1'b0, 0, 8);
    @(negedge clk);
    run_op("fresh1", 32'sd16384, 32'sh2000_0000, 0,    1'b1, 0, 0);
    run_op("fresh2", 32'sd16384, 32'sh2000_0000, 4096, 1'b1, 0, 0);

    repeat (25) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", exp_q.size());
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lms_fir_engine.md
# lms_fir_engine

Adaptive FIR responder on the far side of the core FSM's `fir_go`/`fir_done` handshake. On each `fir_go` pulse the block:
- shifts the new reference sample into its delay line;
- computes the filter output one tap per cycle;
- applies the LMS weight update for every tap using the core's `weight_adjust` product;
- pulses `fir_done` with the new anti-noise sample on `y_out`.

It sits between the core FSM and the output/DAC path.

## Interface
Parameters:
- `TAPS`, 16: number of filter taps. Power of two, 4..64.
- `FRAC`, 15: fractional bits of the Q1.15 sample and weight format.
- `ACC_W`, 40: accumulator width.

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `fir_go`  in  1: one-cycle start pulse from the core.
- `feedforward_in`  in  32 signed: new reference sample, 32-bit sign-extended.
- `weight_adjust`  in  32 signed: (error − desired)·μ, Q2.30.
- `y_out`  out  16 signed: filter output, Q1.15. Held until the next result.
- `fir_done`  out  1: one-cycle pulse; `y_out` is valid in the same cycle.
- `busy`  out  1: high from the cycle after `fir_go` is accepted until `fir_done` is pulsed, inclusive.

## Operation
- Every output has reset value 0. Reset also sets all weights `w[0..TAPS-1]`, the delay line `x[0..TAPS-1]`, the accumulator and the tap counter to 0.
- State machine states: IDLE, MAC, DONE.
- IDLE → MAC when `fir_go` = 1:
  - shift the delay line (`x[k] <= x[k-1]`);
  - `x[0] <= sat16(feedforward_in)`;
  - `mu_e <= sat16(weight_adjust >>> FRAC)`;
  - `acc <= 0`, `k <= 0`.
- MAC, one tap per cycle:
  - `acc <= acc + w[k]*x[k]`. The full Q2.30 product is sign-extended to `ACC_W`.
  - `w[k] <= sat16(w[k] + ((mu_e*x[k]) >>> FRAC))`.
  - The output always uses the pre-update weight of the same cycle.
  - When `k == TAPS-1`, go to DONE; otherwise `k <= k+1`.
- DONE:
  - `y_out <= sat16(acc >>> FRAC)`;
  - `fir_done <= 1` for exactly one cycle;
  - next state IDLE.
- Arithmetic:
  - `sat16` clamps to [−32768, 32767].
  - All shifts are arithmetic and truncate toward −∞. No rounding.
  - The accumulator never wraps for `TAPS` ≤ 64.
- Boundary conditions:
  - `fir_go` outside IDLE is ignored: no queueing, and the latched sample and `mu_e` are unchanged.
  - `fir_go` in the DONE cycle is also ignored.
  - `feedforward_in` and `weight_adjust` are sampled only on the accepting edge.
  - Reset mid-MAC aborts the operation: no `fir_done` pulse, and all state is cleared.

## Timing
- `fir_go` is sampled high at edge E0.
- MAC occupies edges E1..E_TAPS.
- `fir_done` and the new `y_out` are registered at edge E_{TAPS+1}.
- Latency from `fir_go` to `fir_done` is therefore TAPS+1 cycles; TAPS=16 gives 17 cycles.
- Minimum spacing between accepted `fir_go` pulses is TAPS+2 cycles.
- `busy` is high for TAPS+1 cycles per operation.
- The core FSM holds in RUN until `fir_done`, so the handshake needs no backpressure.

## Structure
- Shared package `lms_pkg` holds:
  - the `FRAC` constant;
  - the `sat16` function;
  - the state enum (IDLE/MAC/DONE).
  The core FSM and output stage reuse these.
- Natural sub-module: `lms_tap_alu`, purely combinational. Inputs: `w`, `x`, `mu_e`. Outputs: the sign-extended product and the saturated new weight.
- Weights and delay line are register arrays indexed by `k`. No RAM macro.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `y_out` = 0, `fir_done` = 0, `busy` = 0 immediately; a subsequent `go` with all-zero weights gives `y_out` = 0.
- **Latency:** weights 0, `weight_adjust` = 0, `go` with `feedforward_in` = 16384 → `fir_done` pulses exactly 17 cycles later (TAPS=16), `y_out` = 0, single-cycle pulse.
- **Learning:** `weight_adjust` = 0x2000_0000 (`mu_e` = 16384), `feedforward_in` = 16384, repeated twice:
  - after the first `go`: `y_out` = 0, `w[0]` = 8192;
  - after the second `go`: `y_out` = 4096, `w[0]` = 16384, `w[1]` = 8192.
- **Saturation:**
  - `feedforward_in` = 0x0001_0000 → `x[0]` = 32767;
  - 10 further `go` pulses with `weight_adjust` = 0x3FFF_8000 and the same input → `w[0]` saturates at 32767 and never wraps negative;
  - `y_out` clamps at 32767.
- **Ignored go:** pulse `fir_go` at E5 during MAC with a different sample → no second `fir_done`; the delay line and result match the single-go reference.
- **Abort:** assert `rst` at E8 of MAC → no `fir_done` pulse; a following normal `go` behaves as after a fresh reset.
